regfile_2w_scoreboard: RTL and testbench
========================================

// Module: regfile_2w_scoreboard
// PURPOSE
//  Parametrised multi-port register file for the pipelined core. Provides 2 async read ports, 2 write
//  ports (ALU and LSU writeback) and optional write-to-read bypass. A per-register busy scoreboard is
//  set at issue and cleared at writeback, so decode can stall on RAW hazards.
// PARAMETERS
//  DATA_W    32  register width in bits
//  ADDR_W    5   address width; NREG = 2**ADDR_W registers
//  ZERO_REG  1   1: register 0 reads 0, ignores writes, never busy; 0: register 0 is ordinary
//  BYPASS    1   1: same-cycle write data/clear forwarded to read ports; 0: reads see stored state only
// PORTS
//  CLK       in   1         clock, rising edge
//  RESET_N   in   1         asynchronous reset, active low
//  RA1       in   ADDR_W    read address, port 1
//  RA2       in   ADDR_W    read address, port 2
//  RD1       out  DATA_W    read data, port 1 (combinational)
//  RD2       out  DATA_W    read data, port 2 (combinational)
//  RBUSY1    out  1         register at RA1 has a pending producer
//  RBUSY2    out  1         register at RA2 has a pending producer
//  WE0       in   1         write enable, port 0 (ALU)
//  WA0       in   ADDR_W    write address, port 0
//  WD0       in   DATA_W    write data, port 0
//  WE1       in   1         write enable, port 1 (LSU); has priority over port 0
//  WA1       in   ADDR_W    write address, port 1
//  WD1       in   DATA_W    write data, port 1
//  RSV_EN    in   1         reserve: mark RSV_A busy (instruction issued)
//  RSV_A     in   ADDR_W    destination register being reserved
//  BUSY_CNT  out  ADDR_W+1  registered count of busy registers
// BEHAVIOUR
//  Reset: RESET_N low clears all registers, busy bits and BUSY_CNT to 0 immediately, regardless of CLK.
//   Read outputs then follow from the cleared state. Any write or reserve in progress is discarded.
//  Write: on rising CLK, if WEn is set, REG[WAn] <= WDn.
//   If WE0 and WE1 target the same address, only WD1 is stored.
//   With ZERO_REG=1, writes to address 0 are dropped.
//  Read: RDk = REG[RAk], purely combinational, zero latency.
//   With ZERO_REG=1 and RAk==0, RDk = 0.
//   With BYPASS=1 and a same-cycle write hit on RAk, RDk returns the incoming data (WD1 over WD0).
//  Scoreboard update at rising CLK, per address a (with ZERO_REG=1, a==0 is never set):
//   set if RSV_EN and RSV_A==a;
//   else cleared if a write hits a (either port);
//   else unchanged.
//   Reserve and write to the same address in the same cycle leaves the bit SET: the newer producer wins.
//  RBUSYk = busy[RAk], masked to 0 when BYPASS=1 and a same-cycle write hits RAk.
//   RSV_EN never affects RBUSY in the same cycle.
//  BUSY_CNT: registered, equals popcount of the busy bits after each edge.
//   Per cycle it changes by +1, 0, -1 or -2 (e.g. two clears on different addresses).
//   Its maximum value is NREG-ZERO_REG.
//  Reserving an already-busy register keeps it busy; BUSY_CNT is unchanged.
//  Writing a non-busy register updates data only; BUSY_CNT is unchanged.
// TESTING
//  1 Reset: preload regs, pulse RESET_N low between edges -> all RDk=0, RBUSYk=0, BUSY_CNT=0 at once.
//  2 Write-conflict: WE0=WE1=1, WA0=WA1=7, WD0=0x11, WD1=0x22 -> next cycle RD1(RA1=7)=0x22.
//    Same-cycle RD1 is 0x22 with BYPASS=1, old value with BYPASS=0.
//  3 Zero reg: ZERO_REG=1, write 0xDEAD to r0, RSV_A=0 -> RD1(RA1=0)=0, RBUSY1=0, BUSY_CNT=0.
//  4 Scoreboard: reserve r3, then r5 -> BUSY_CNT=2; write r3 via WE0 -> RBUSY(r3) masked same cycle,
//    BUSY_CNT=1 next cycle.
//  5 Race: RSV_EN on r9 together with WE1 to r9 -> r9 stays busy, REG[9]=WD1, BUSY_CNT +1.
//  6 Double clear: r4 and r6 busy, WE0->r4 and WE1->r6 in one cycle -> BUSY_CNT drops by 2, both idle.

Source files
------------

// File: rtl/regfile_2w_scoreboard_if.sv
// Register file bus: two read ports, two writeback ports, issue reservation and busy count.
interface regfile_2w_scoreboard_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
);
   logic [ADDR_W-1:0] RA1;
   logic [ADDR_W-1:0] RA2;
   logic [DATA_W-1:0] RD1;
   logic [DATA_W-1:0] RD2;
   logic              RBUSY1;
   logic              RBUSY2;
   logic              WE0;
   logic [ADDR_W-1:0] WA0;
   logic [DATA_W-1:0] WD0;
   logic              WE1;
   logic [ADDR_W-1:0] WA1;
   logic [DATA_W-1:0] WD1;
   logic              RSV_EN;
   logic [ADDR_W-1:0] RSV_A;
   logic [ADDR_W:0]   BUSY_CNT;

   // Core side: drives addresses, writebacks and reservations.
   modport master (
      output RA1, RA2, WE0, WA0, WD0, WE1, WA1, WD1, RSV_EN, RSV_A,
      input  RD1, RD2, RBUSY1, RBUSY2, BUSY_CNT
   );

   // Register file side.
   modport slave (
      input  RA1, RA2, WE0, WA0, WD0, WE1, WA1, WD1, RSV_EN, RSV_A,
      output RD1, RD2, RBUSY1, RBUSY2, BUSY_CNT
   );
endinterface

// File: rtl/regfile_2w_scoreboard.sv
// Two-read / two-write register file with per-register busy scoreboard for RAW stalls.
// Write port 1 (LSU) has priority over port 0 (ALU) on an address collision.
module regfile_2w_scoreboard #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned BYPASS   = 1
) (
   input logic                    CLK,
   input logic                    RESET_N,
   regfile_2w_scoreboard_if.slave bus
);
   localparam int unsigned NREG = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs_q [NREG];
   logic [NREG-1:0]   busy_q, busy_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;

   logic              we0_ok, we1_ok, rsv_ok;
   logic [ADDR_W-1:0] wa0, wa1, rsv_a;
   logic [DATA_W-1:0] wd0, wd1;
   logic [NREG-1:0]   hit0, hit1, hit_rsv;

   assign wa0   = bus.WA0;
   assign wa1   = bus.WA1;
   assign wd0   = bus.WD0;
   assign wd1   = bus.WD1;
   assign rsv_a = bus.RSV_A;

   // Hardwired r0 swallows writes and reservations so it can never look busy.
   assign we0_ok = bus.WE0 && !(ZERO_REG != 0 && wa0 == '0);
   assign we1_ok = bus.WE1 && !(ZERO_REG != 0 && wa1 == '0);
   assign rsv_ok = bus.RSV_EN && !(ZERO_REG != 0 && rsv_a == '0);

   // Decode write and reserve addresses into per-register hit vectors.
   always_comb begin
      hit0    = '0;
      hit1    = '0;
      hit_rsv = '0;
      for (int i = 0; i < NREG; i++) begin
         hit0[i]    = we0_ok && (wa0 == ADDR_W'(i));
         hit1[i]    = we1_ok && (wa1 == ADDR_W'(i));
         hit_rsv[i] = rsv_ok && (rsv_a == ADDR_W'(i));
      end
   end

   // Register storage; port 1 data wins when both ports hit the same register.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (hit1[i])      regs_q[i] <= wd1;
            else if (hit0[i]) regs_q[i] <= wd0;
         end
      end
   end

   // Next busy state: a reservation beats a same-cycle writeback (newer producer wins).
   always_comb begin
      busy_d = busy_q;
      for (int i = 0; i < NREG; i++) begin
         if (hit_rsv[i])               busy_d[i] = 1'b1;
         else if (hit0[i] || hit1[i])  busy_d[i] = 1'b0;
      end
      cnt_d = (ADDR_W + 1)'($countones(busy_d));
   end

   // Scoreboard and busy count registers.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   // Read mux returning {busy, data}; bypass forwards incoming data and masks busy.
   function automatic logic [DATA_W:0] rd_mux(input logic [ADDR_W-1:0] ra);
      logic [DATA_W-1:0] d;
      logic              b;
      d = regs_q[ra];
      b = busy_q[ra];
      if (BYPASS != 0) begin
         if (we1_ok && wa1 == ra) begin
            d = wd1;
            b = 1'b0;
         end else if (we0_ok && wa0 == ra) begin
            d = wd0;
            b = 1'b0;
         end
      end
      if (ZERO_REG != 0 && ra == '0) begin
         d = '0;
         b = 1'b0;
      end
      return {b, d};
   endfunction

   // Combinational read ports.
   always_comb begin
      {bus.RBUSY1, bus.RD1} = rd_mux(bus.RA1);
      {bus.RBUSY2, bus.RD2} = rd_mux(bus.RA2);
   end

   assign bus.BUSY_CNT = cnt_q;
endmodule

// File: tb/tb_regfile_2w_scoreboard.sv
// Directed bench: DUT a uses defaults (ZERO_REG=1, BYPASS=1); DUT b has ZERO_REG=0, BYPASS=0.
module tb_regfile_2w_scoreboard;
   logic CLK;
   logic RESET_N;
   int   n_assert;
   int   n_fail;

   regfile_2w_scoreboard_if #(.DATA_W(32), .ADDR_W(5)) ifa ();
   regfile_2w_scoreboard_if #(.DATA_W(32), .ADDR_W(5)) ifb ();

   regfile_2w_scoreboard #(
      .DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)
   ) u_a (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .bus     (ifa.slave)
   );

   regfile_2w_scoreboard #(
      .DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)
   ) u_b (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .bus     (ifb.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_w0(input logic en, input logic [4:0] a, input logic [31:0] d);
      ifa.WE0 = en; ifa.WA0 = a; ifa.WD0 = d;
      ifb.WE0 = en; ifb.WA0 = a; ifb.WD0 = d;
   endtask

   task automatic set_w1(input logic en, input logic [4:0] a, input logic [31:0] d);
      ifa.WE1 = en; ifa.WA1 = a; ifa.WD1 = d;
      ifb.WE1 = en; ifb.WA1 = a; ifb.WD1 = d;
   endtask

   task automatic set_rsv(input logic en, input logic [4:0] a);
      ifa.RSV_EN = en; ifa.RSV_A = a;
      ifb.RSV_EN = en; ifb.RSV_A = a;
   endtask

   task automatic set_ra(input logic [4:0] a1, input logic [4:0] a2);
      ifa.RA1 = a1; ifa.RA2 = a2;
      ifb.RA1 = a1; ifb.RA2 = a2;
   endtask

   task automatic idle();
      set_w0(1'b0, 5'd0, 32'h0);
      set_w1(1'b0, 5'd0, 32'h0);
      set_rsv(1'b0, 5'd0);
   endtask

   // Advance past the next rising edge; inputs change and samples land 1 ns after it.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      RESET_N  = 1'b0;
      idle();
      set_ra(5'd0, 5'd0);
      #12;
      RESET_N = 1'b1;
      tick();

      // Preload: r1, r2 written, r10 reserved.
      set_w0(1'b1, 5'd1, 32'hA5A5);
      set_w1(1'b1, 5'd2, 32'h5A5A);
      set_rsv(1'b1, 5'd10);
      tick();
      idle();
      set_ra(5'd1, 5'd2);
      #1;
      chk("preload_rd1", ifa.RD1, 32'hA5A5);
      chk("preload_rd2", ifa.RD2, 32'h5A5A);
      chk("preload_cnt", 32'(ifa.BUSY_CNT), 32'd1);
      set_ra(5'd1, 5'd10);
      #1;
      chk("preload_busy10", 32'(ifa.RBUSY2), 32'd1);

      // Reset pulse between edges: cleared immediately.
      RESET_N = 1'b0;
      #1;
      chk("reset_rd1_a", ifa.RD1, 32'h0);
      chk("reset_rd1_b", ifb.RD1, 32'h0);
      chk("reset_rbusy2", 32'(ifa.RBUSY2), 32'd0);
      chk("reset_cnt", 32'(ifa.BUSY_CNT), 32'd0);
      #1;
      RESET_N = 1'b1;
      tick();

      // Write conflict on r7: port 1 data wins; bypass only on a.
      set_w0(1'b1, 5'd7, 32'h11);
      set_w1(1'b1, 5'd7, 32'h22);
      set_ra(5'd7, 5'd0);
      #1;
      chk("conflict_byp_a", ifa.RD1, 32'h22);
      chk("conflict_nobyp_b", ifb.RD1, 32'h0);
      tick();
      idle();
      #1;
      chk("conflict_stored_a", ifa.RD1, 32'h22);
      chk("conflict_stored_b", ifb.RD1, 32'h22);

      // Zero register: write and reserve r0.
      set_w0(1'b1, 5'd0, 32'hDEAD);
      set_rsv(1'b1, 5'd0);
      set_ra(5'd0, 5'd0);
      #1;
      chk("zero_byp_a", ifa.RD1, 32'h0);
      tick();
      idle();
      #1;
      chk("zero_rd_a", ifa.RD1, 32'h0);
      chk("zero_busy_a", 32'(ifa.RBUSY1), 32'd0);
      chk("zero_cnt_a", 32'(ifa.BUSY_CNT), 32'd0);
      chk("r0_rd_b", ifb.RD1, 32'hDEAD);
      chk("r0_busy_b", 32'(ifb.RBUSY1), 32'd1);
      chk("r0_cnt_b", 32'(ifb.BUSY_CNT), 32'd1);
      set_w0(1'b1, 5'd0, 32'hBEEF);
      tick();
      idle();
      #1;
      chk("r0_clear_cnt_b", 32'(ifb.BUSY_CNT), 32'd0);
      chk("r0_rd2_b", ifb.RD1, 32'hBEEF);
      chk("zero_rd2_a", ifa.RD1, 32'h0);

      // Scoreboard: reserve r3 then r5, write r3 via port 0.
      set_rsv(1'b1, 5'd3);
      tick();
      set_rsv(1'b1, 5'd5);
      tick();
      idle();
      set_ra(5'd3, 5'd5);
      #1;
      chk("sb_cnt2", 32'(ifa.BUSY_CNT), 32'd2);
      chk("sb_busy3", 32'(ifa.RBUSY1), 32'd1);
      chk("sb_busy5", 32'(ifa.RBUSY2), 32'd1);
      set_w0(1'b1, 5'd3, 32'h33);
      #1;
      chk("sb_mask_a", 32'(ifa.RBUSY1), 32'd0);
      chk("sb_nomask_b", 32'(ifb.RBUSY1), 32'd1);
      chk("sb_byp_rd_a", ifa.RD1, 32'h33);
      chk("sb_busy5_hold", 32'(ifa.RBUSY2), 32'd1);
      tick();
      idle();
      #1;
      chk("sb_cnt1_a", 32'(ifa.BUSY_CNT), 32'd1);
      chk("sb_cnt1_b", 32'(ifb.BUSY_CNT), 32'd1);
      chk("sb_idle3", 32'(ifa.RBUSY1), 32'd0);
      chk("sb_rd3", ifa.RD1, 32'h33);

      // Race: reserve r9 together with port-1 write to r9.
      set_rsv(1'b1, 5'd9);
      set_w1(1'b1, 5'd9, 32'h99);
      set_ra(5'd9, 5'd5);
      #1;
      chk("race_same_busy", 32'(ifa.RBUSY1), 32'd0);
      chk("race_same_rd", ifa.RD1, 32'h99);
      tick();
      idle();
      #1;
      chk("race_busy", 32'(ifa.RBUSY1), 32'd1);
      chk("race_rd", ifa.RD1, 32'h99);
      chk("race_cnt", 32'(ifa.BUSY_CNT), 32'd2);

      // Double clear: r4 and r6 busy, written on both ports together.
      set_rsv(1'b1, 5'd4);
      tick();
      set_rsv(1'b1, 5'd6);
      tick();
      idle();
      #1;
      chk("dc_cnt4", 32'(ifa.BUSY_CNT), 32'd4);
      set_w0(1'b1, 5'd4, 32'h44);
      set_w1(1'b1, 5'd6, 32'h66);
      set_ra(5'd4, 5'd6);
      #1;
      chk("dc_mask1_a", 32'(ifa.RBUSY1), 32'd0);
      chk("dc_mask2_a", 32'(ifa.RBUSY2), 32'd0);
      chk("dc_nomask2_b", 32'(ifb.RBUSY2), 32'd1);
      tick();
      idle();
      #1;
      chk("dc_cnt2", 32'(ifa.BUSY_CNT), 32'd2);
      chk("dc_idle4", 32'(ifa.RBUSY1), 32'd0);
      chk("dc_idle6", 32'(ifa.RBUSY2), 32'd0);
      chk("dc_rd4", ifa.RD1, 32'h44);
      chk("dc_rd6", ifa.RD2, 32'h66);

      // Reserve an already-busy r5, then write a non-busy r12: count unchanged.
      set_rsv(1'b1, 5'd5);
      tick();
      idle();
      #1;
      chk("rerserve_cnt", 32'(ifa.BUSY_CNT), 32'd2);
      set_w0(1'b1, 5'd12, 32'hC0C0);
      set_ra(5'd12, 5'd5);
      tick();
      idle();
      #1;
      chk("nonbusy_wr_cnt", 32'(ifa.BUSY_CNT), 32'd2);
      chk("nonbusy_wr_rd", ifa.RD1, 32'hC0C0);
      chk("r5_still_busy", 32'(ifa.RBUSY2), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
